// File: rtl/bingo_call_tracker_if.sv
// Keyboard/board/result bundle between the caller and bingo_call_tracker.
// The master drives the call request and the board; the slave reports call results.
interface bingo_call_tracker_if;
    logic [7:0]   display_num;
    logic         enter_pulse;
    logic [124:0] board_cells;
    logic         busy;
    logic         call_done;
    logic         call_reject;
    logic [4:0]   call_num;
    logic [24:0]  marked;
    logic [3:0]   line_count;
    logic         win;

    modport master (
        output display_num, enter_pulse, board_cells,
        input  busy, call_done, call_reject, call_num, marked, line_count, win
    );

    modport slave (
        input  display_num, enter_pulse, board_cells,
        output busy, call_done, call_reject, call_num, marked, line_count, win
    );
endinterface

// File: rtl/bingo_call_tracker.sv
// Bingo call tracker: validates a BCD call, marks the first matching board cell,
// then walks the 12 bingo lines to update the completed-line count and win flag.
module bingo_call_tracker #(
    parameter int MAX_NUM   = 25,
    parameter int WIN_LINES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 interboard_rst,
    bingo_call_tracker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_VALIDATE = 2'd1,
        ST_SCAN     = 2'd2,
        ST_LINES    = 2'd3
    } state_t;

    localparam logic [6:0] MAX_NUM_C   = 7'(MAX_NUM);
    localparam logic [3:0] WIN_LINES_C = 4'(WIN_LINES);
    localparam logic [4:0] LAST_CELL   = 5'd24;
    localparam logic [3:0] LAST_LINE   = 4'd11;

    // Cells of line idx: rows 0-4, columns 0-4, main diagonal, anti-diagonal.
    function automatic logic [24:0] line_mask(input logic [3:0] idx);
        logic [24:0] m;
        case (idx)
            4'd0:    m = 25'h000001F;
            4'd1:    m = 25'h00003E0;
            4'd2:    m = 25'h0007C00;
            4'd3:    m = 25'h00F8000;
            4'd4:    m = 25'h1F00000;
            4'd5:    m = 25'h0108421;
            4'd6:    m = 25'h0210842;
            4'd7:    m = 25'h0421084;
            4'd8:    m = 25'h0842108;
            4'd9:    m = 25'h1084210;
            4'd10:   m = 25'h1041041;
            4'd11:   m = 25'h0111110;
            default: m = 25'h0000000;
        endcase
        return m;
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  num_q, num_d;
    logic        bcd_bad_q, bcd_bad_d;
    logic [24:0] called_q, called_d;
    logic [4:0]  scan_idx_q, scan_idx_d;
    logic [3:0]  line_idx_q, line_idx_d;
    logic [3:0]  lines_acc_q, lines_acc_d;
    logic        busy_q, busy_d;
    logic        call_done_q, call_done_d;
    logic        call_reject_q, call_reject_d;
    logic [4:0]  call_num_q, call_num_d;
    logic [24:0] marked_q, marked_d;
    logic [3:0]  line_count_q, line_count_d;
    logic        win_q, win_d;

    logic        reset_s;
    logic [3:0]  tens_s;
    logic [3:0]  ones_s;
    logic        dup_s;
    logic        reject_s;
    logic [4:0]  cell_s;
    logic        match_s;
    logic        line_hit_s;
    logic [3:0]  line_total_s;

    assign reset_s = rst | interboard_rst;
    assign tens_s  = bus.display_num[7:4];
    assign ones_s  = bus.display_num[3:0];

    // Per-cycle decisions: duplicate/validity check, current cell compare, current line test.
    always_comb begin
        dup_s  = 1'b0;
        cell_s = 5'd0;
        for (int i = 0; i < 25; i++) begin
            dup_s  = dup_s | (called_q[i] & (num_q == 7'(i + 1)));
            cell_s = cell_s | (bus.board_cells[5*i +: 5] & {5{scan_idx_q == 5'(i)}});
        end
        reject_s     = bcd_bad_q | (num_q == 7'd0) | (num_q > MAX_NUM_C) | dup_s;
        match_s      = (cell_s == call_num_q);
        line_hit_s   = ((marked_q & line_mask(line_idx_q)) == line_mask(line_idx_q));
        line_total_s = lines_acc_q + {3'b000, line_hit_s};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset_s) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enter_pulse) begin
                    state_d = ST_VALIDATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VALIDATE: begin
                if (reject_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (match_s || (scan_idx_q == LAST_CELL)) begin
                    state_d = ST_LINES;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_LINES: begin
                if (line_idx_q == LAST_LINE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LINES;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values for each state.
    always_comb begin
        num_d         = num_q;
        bcd_bad_d     = bcd_bad_q;
        called_d      = called_q;
        scan_idx_d    = scan_idx_q;
        line_idx_d    = line_idx_q;
        lines_acc_d   = lines_acc_q;
        busy_d        = busy_q;
        call_done_d   = 1'b0;
        call_reject_d = 1'b0;
        call_num_d    = call_num_q;
        marked_d      = marked_q;
        line_count_d  = line_count_q;
        win_d         = win_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enter_pulse) begin
                    num_d     = ({3'b000, tens_s} * 7'd10) + {3'b000, ones_s};
                    bcd_bad_d = (tens_s > 4'd9) | (ones_s > 4'd9);
                    busy_d    = 1'b1;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            ST_VALIDATE: begin
                if (reject_s) begin
                    call_reject_d = 1'b1;
                    busy_d        = 1'b0;
                end else begin
                    for (int i = 0; i < 25; i++) begin
                        called_d[i] = called_q[i] | (num_q == 7'(i + 1));
                    end
                    call_num_d  = num_q[4:0];
                    scan_idx_d  = 5'd0;
                    line_idx_d  = 4'd0;
                    lines_acc_d = 4'd0;
                end
            end
            ST_SCAN: begin
                // The first match ends the scan, so duplicates at higher indices stay unmarked.
                if (match_s) begin
                    for (int i = 0; i < 25; i++) begin
                        marked_d[i] = marked_q[i] | (scan_idx_q == 5'(i));
                    end
                end else begin
                    scan_idx_d = scan_idx_q + 5'd1;
                end
            end
            ST_LINES: begin
                if (line_idx_q == LAST_LINE) begin
                    line_count_d = line_total_s;
                    win_d        = win_q | (line_total_s >= WIN_LINES_C);
                    call_done_d  = 1'b1;
                    busy_d       = 1'b0;
                end else begin
                    lines_acc_d  = line_total_s;
                    line_idx_d   = line_idx_q + 4'd1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset_s) begin
            num_q         <= 7'd0;
            bcd_bad_q     <= 1'b0;
            called_q      <= 25'd0;
            scan_idx_q    <= 5'd0;
            line_idx_q    <= 4'd0;
            lines_acc_q   <= 4'd0;
            busy_q        <= 1'b0;
            call_done_q   <= 1'b0;
            call_reject_q <= 1'b0;
            call_num_q    <= 5'd0;
            marked_q      <= 25'd0;
            line_count_q  <= 4'd0;
            win_q         <= 1'b0;
        end else begin
            num_q         <= num_d;
            bcd_bad_q     <= bcd_bad_d;
            called_q      <= called_d;
            scan_idx_q    <= scan_idx_d;
            line_idx_q    <= line_idx_d;
            lines_acc_q   <= lines_acc_d;
            busy_q        <= busy_d;
            call_done_q   <= call_done_d;
            call_reject_q <= call_reject_d;
            call_num_q    <= call_num_d;
            marked_q      <= marked_d;
            line_count_q  <= line_count_d;
            win_q         <= win_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.call_done   = call_done_q;
    assign bus.call_reject = call_reject_q;
    assign bus.call_num    = call_num_q;
    assign bus.marked      = marked_q;
    assign bus.line_count  = line_count_q;
    assign bus.win         = win_q;

endmodule

// File: tb/tb_bingo_call_tracker.sv
// Directed bench for bingo_call_tracker: a reference model pushes expected call
// results into a queue, which are popped and compared when call_done/call_reject fires.
module tb_bingo_call_tracker;

    typedef struct {
        bit          rej;
        int          lat;
        logic [4:0]  num;
        logic [24:0] mk;
        logic [3:0]  lc;
        bit          w;
    } exp_t;

    logic clk;
    logic rst;
    logic interboard_rst;

    bingo_call_tracker_if bif ();

    bingo_call_tracker #(.MAX_NUM(25), .WIN_LINES(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .bus            (bif.slave)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [4:0]  board_m [25];
    logic [24:0] called_m;
    logic [24:0] marked_m;
    logic [4:0]  callnum_m;
    int          lc_m;
    bit          win_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bif.board_cells = '0;
        for (int i = 0; i < 25; i++) begin
            bif.board_cells[5*i +: 5] = board_m[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_lines(input logic [24:0] m);
        int n;
        bit r, c, d, a;
        n = 0;
        d = 1'b1;
        a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            r = 1'b1;
            c = 1'b1;
            for (int j = 0; j < 5; j++) begin
                r = r & m[5*k + j];
                c = c & m[5*j + k];
            end
            n = n + int'(r) + int'(c);
            d = d & m[5*k + k];
            a = a & m[5*k + (4 - k)];
        end
        return n + int'(d) + int'(a);
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    task automatic model_clear();
        called_m  = 25'd0;
        marked_m  = 25'd0;
        callnum_m = 5'd0;
        lc_m      = 0;
        win_m     = 1'b0;
        sb_q.delete();
    endtask

    // Called at posedge+#1 with the DUT idle; issues one call and checks its result.
    task automatic do_call(input logic [7:0] disp, input bit inject);
        exp_t e;
        exp_t got;
        int   tens, ones, n, idx, cycles;
        tens = int'(disp[7:4]);
        ones = int'(disp[3:0]);
        n    = tens * 10 + ones;
        if (tens > 9 || ones > 9 || n == 0 || n > 25) begin
            e.rej = 1'b1;
        end else begin
            e.rej = called_m[n - 1];
        end
        if (e.rej) begin
            e.lat = 1;
        end else begin
            called_m[n - 1] = 1'b1;
            idx = -1;
            for (int i = 24; i >= 0; i--) begin
                if (board_m[i] == 5'(n)) idx = i;
            end
            if (idx >= 0) begin
                marked_m[idx] = 1'b1;
                e.lat = 1 + (idx + 1) + 12;
            end else begin
                e.lat = 1 + 25 + 12;
            end
            callnum_m = 5'(n);
            lc_m = count_lines(marked_m);
            if (lc_m >= 5) win_m = 1'b1;
        end
        e.num = callnum_m;
        e.mk  = marked_m;
        e.lc  = 4'(lc_m);
        e.w   = win_m;
        sb_q.push_back(e);

        bif.display_num = disp;
        bif.enter_pulse = 1'b1;
        @(posedge clk); #1;
        bif.enter_pulse = 1'b0;
        check("busy_after_enter", 32'(bif.busy), 32'd1);
        check("pulses_low_after_enter", 32'({bif.call_done, bif.call_reject}), 32'd0);
        cycles = 0;
        while (cycles < 60 && !(bif.call_done || bif.call_reject)) begin
            if (inject && cycles == 3) begin
                bif.display_num = 8'h08;
                bif.enter_pulse = 1'b1;
            end
            @(posedge clk); #1;
            bif.enter_pulse = 1'b0;
            cycles++;
        end
        got = sb_q.pop_front();
        check("result_within_budget", 32'(cycles < 60), 32'd1);
        check("call_reject", 32'(bif.call_reject), 32'(got.rej));
        check("call_done", 32'(bif.call_done), 32'(!got.rej));
        check("latency", 32'(cycles), 32'(got.lat));
        check("busy_cleared", 32'(bif.busy), 32'd0);
        check("call_num", 32'(bif.call_num), 32'(got.num));
        check("marked", 32'(bif.marked), 32'(got.mk));
        check("line_count", 32'(bif.line_count), 32'(got.lc));
        check("win", 32'(bif.win), 32'(got.w));
    endtask

    initial begin
        int seq_c[25] = '{1, 2, 3, 4, 5, 6, 11, 16, 21, 7, 8, 9, 10, 12, 13,
                          14, 15, 17, 18, 19, 20, 22, 23, 24, 25};
        int cnt;

        rst             = 1'b1;
        interboard_rst  = 1'b0;
        bif.display_num = 8'h00;
        bif.enter_pulse = 1'b0;
        for (int i = 0; i < 25; i++) board_m[i] = 5'(i + 1);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_done", 32'(bif.call_done), 32'd0);
        check("rst_reject", 32'(bif.call_reject), 32'd0);
        check("rst_call_num", 32'(bif.call_num), 32'd0);
        check("rst_marked", 32'(bif.marked), 32'd0);
        check("rst_line_count", 32'(bif.line_count), 32'd0);
        check("rst_win", 32'(bif.win), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Invalid calls leave the called set empty, so 7 is still accepted afterwards.
        do_call(8'h00, 1'b0);
        do_call(8'h26, 1'b0);
        do_call(8'h1A, 1'b0);
        do_call(8'h07, 1'b1);
        do_call(8'h08, 1'b0);
        do_call(8'h07, 1'b0);

        // Reset with a coincident enter: the enter must be discarded.
        rst             = 1'b1;
        bif.display_num = 8'h09;
        bif.enter_pulse = 1'b1;
        @(posedge clk); #1;
        rst             = 1'b0;
        bif.enter_pulse = 1'b0;
        model_clear();
        check("rst_clears_marked", 32'(bif.marked), 32'd0);
        check("rst_clears_call_num", 32'(bif.call_num), 32'd0);
        @(posedge clk); #1;
        check("rst_enter_discarded", 32'(bif.busy), 32'd0);

        // Row 0, then column 0, then the whole board.
        for (int k = 0; k < 25; k++) do_call(to_bcd(seq_c[k]), 1'b0);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        for (int k = 1; k <= 24; k++) do_call(to_bcd(k), 1'b0);

        // Peer reset while scanning toward the last cell aborts the call.
        bif.display_num = 8'h25;
        bif.enter_pulse = 1'b1;
        @(posedge clk); #1;
        bif.enter_pulse = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("busy_mid_scan", 32'(bif.busy), 32'd1);
        interboard_rst = 1'b1;
        @(posedge clk); #1;
        interboard_rst = 1'b0;
        model_clear();
        check("ibrst_busy", 32'(bif.busy), 32'd0);
        check("ibrst_marked", 32'(bif.marked), 32'd0);
        check("ibrst_win", 32'(bif.win), 32'd0);
        check("ibrst_line_count", 32'(bif.line_count), 32'd0);
        cnt = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (bif.call_done || bif.call_reject) cnt++;
        end
        check("ibrst_no_result", 32'(cnt), 32'd0);
        do_call(8'h07, 1'b0);

        // Value absent from the board, then a duplicated value.
        board_m[10] = 5'd0;
        do_call(8'h11, 1'b0);
        board_m[3] = 5'd9;
        do_call(8'h09, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
